// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// Memory stage of a five-stage pipeline: latches the exe-stage bus, aligns and extends
// load data from a synchronous SRAM, and holds that data across writeback backpressure.
module mem_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ws_allowin,
   output logic        ms_allowin,
   input  logic        es_to_ms_valid,
   input  logic [78:0] es_to_ms_bus,
   output logic        ms_to_ws_valid,
   output logic [69:0] ms_to_ws_bus,
   input  logic [31:0] data_sram_rdata,
   output logic [4:0]  mem_waddr,
   output logic [31:0] mem_wdata,
   output logic        mem_is_load
);

   logic        ms_valid_q;
   logic        first_q;
   logic        hold_valid_q;
   logic [31:0] hold_q;
   logic [78:0] bus_q;

   logic        ms_ready_go;
   logic        accept;
   logic        hold_load;

   logic [1:0]  ld_off;
   logic [2:0]  ld_code;
   logic [1:0]  st_code;
   logic        mem_we;
   logic        res_from_mem;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;

   logic [31:0] raw;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_result;
   logic [31:0] final_result;

   assign {ld_off, ld_code, st_code, mem_we, res_from_mem, gr_we, dest, alu_result, pc} = bus_q;

   // Store controls travel with the instruction but are consumed elsewhere.
   logic unused_store_bits;
   assign unused_store_bits = ^{st_code, mem_we};

   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
   assign accept         = es_to_ms_valid && ms_allowin;

   // SRAM data is only valid in the first cycle; keep it if writeback stalls us then.
   assign hold_load = ms_valid_q && first_q && res_from_mem && !ws_allowin;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_q   <= 1'b0;
         first_q      <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_q       <= 32'h0;
         bus_q        <= 79'h0;
      end else begin
         first_q <= accept;
         if (ms_allowin) begin
            ms_valid_q <= es_to_ms_valid;
         end
         if (accept) begin
            bus_q <= es_to_ms_bus;
         end
         if (ms_allowin) begin
            hold_valid_q <= 1'b0;
         end else if (hold_load) begin
            hold_valid_q <= 1'b1;
            hold_q       <= data_sram_rdata;
         end
      end
   end

   assign raw     = hold_valid_q ? hold_q : data_sram_rdata;
   assign ld_byte = raw[{ld_off, 3'b000} +: 8];
   assign ld_half = raw[{ld_off[1], 4'b0000} +: 16];

   always_comb begin
      load_result = raw;
      case (ld_code)
         3'b001:  load_result = {{24{ld_byte[7]}}, ld_byte};
         3'b011:  load_result = {24'h0, ld_byte};
         3'b010:  load_result = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_result = {16'h0, ld_half};
         default: load_result = raw;
      endcase
   end

   assign final_result = res_from_mem ? load_result : alu_result;

   assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
   assign mem_waddr    = dest & {5{gr_we && ms_valid_q}};
   assign mem_wdata    = final_result;
   assign mem_is_load  = ms_valid_q && res_from_mem;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
// Bench for mem_stage: directed load/stall/backpressure/reset scenarios followed by random
// traffic, all checked against an instruction-level model of the stage.
module tb_mem_stage;

   logic        clk;
   logic        resetn;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [78:0] es_to_ms_bus;
   logic        ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic [31:0] data_sram_rdata;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_is_load;

   int tests;
   int fails;

   // Model: the instruction occupying the stage and the SRAM word it saw on arrival.
   bit          m_valid;
   bit          m_first;
   logic [78:0] m_bus;
   logic [31:0] m_data;

   mem_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .ws_allowin      (ws_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .data_sram_rdata (data_sram_rdata),
      .mem_waddr       (mem_waddr),
      .mem_wdata       (mem_wdata),
      .mem_is_load     (mem_is_load)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [78:0] mk_bus(input logic [1:0] off, input logic [2:0] code,
                                          input logic rfm, input logic gwe,
                                          input logic [4:0] dst, input logic [31:0] alu,
                                          input logic [31:0] pcv);
      logic [1:0] st;
      logic       we;
      st = 2'($urandom);
      we = 1'($urandom);
      return {off, code, st, we, rfm, gwe, dst, alu, pcv};
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] rawv, input logic [2:0] code,
                                            input logic [1:0] off);
      logic [31:0] b;
      logic [31:0] h;
      b = (rawv >> (8 * int'(off))) & 32'hFF;
      h = (rawv >> (16 * (int'(off) / 2))) & 32'hFFFF;
      case (code)
         3'd1:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
         3'd3:    return b;
         3'd2:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
         3'd4:    return h;
         default: return rawv;
      endcase
   endfunction

   function automatic logic [31:0] exp_result();
      logic [31:0] rawv;
      rawv = m_first ? data_sram_rdata : m_data;
      return m_bus[70] ? load_val(rawv, m_bus[76:74], m_bus[78:77]) : m_bus[63:32];
   endfunction

   task automatic drive(input logic esv, input logic [78:0] bus, input logic ws,
                        input logic [31:0] rd);
      es_to_ms_valid  = esv;
      es_to_ms_bus    = bus;
      ws_allowin      = ws;
      data_sram_rdata = rd;
   endtask

   // Called at posedge+1 with inputs already driven; checks at the falling edge.
   task automatic settle(input string tag);
      logic [31:0] res;
      #4;
      res = exp_result();
      check({tag, ".allowin"}, 70'(ms_allowin), 70'(!m_valid || ws_allowin));
      check({tag, ".valid"}, 70'(ms_to_ws_valid), 70'(m_valid));
      check({tag, ".is_load"}, 70'(mem_is_load), 70'(m_valid && m_bus[70]));
      check({tag, ".waddr"}, 70'(mem_waddr), 70'((m_valid && m_bus[69]) ? m_bus[68:64] : 5'd0));
      if (m_valid) begin
         check({tag, ".bus"}, ms_to_ws_bus, {m_bus[69], m_bus[68:64], res, m_bus[31:0]});
         check({tag, ".wdata"}, 70'(mem_wdata), 70'(res));
      end
   endtask

   task automatic tick();
      bit acc;
      acc = !m_valid || ws_allowin;
      if (m_first) m_data = data_sram_rdata;
      m_first = 1'b0;
      if (acc) begin
         m_valid = es_to_ms_valid;
         if (es_to_ms_valid) begin
            m_bus   = es_to_ms_bus;
            m_first = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input string tag);
      settle(tag);
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".allowin"}, 70'(ms_allowin), 70'(1'b1));
      check({tag, ".valid"}, 70'(ms_to_ws_valid), 70'(1'b0));
      check({tag, ".waddr"}, 70'(mem_waddr), 70'(5'd0));
      check({tag, ".is_load"}, 70'(mem_is_load), 70'(1'b0));
      check({tag, ".wdata"}, 70'(mem_wdata), 70'(32'd0));
   endtask

   logic [78:0] ld_bus [4];
   logic [31:0] ld_exp [4];

   initial begin
      tests   = 0;
      fails   = 0;
      m_valid = 1'b0;
      m_first = 1'b0;
      m_bus   = '0;
      m_data  = '0;
      resetn  = 1'b0;
      drive(1'b0, '0, 1'b1, 32'h0);
      #3;
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      resetn = 1'b1;

      // ld.w, data one cycle after accept, single-cycle hand-off
      drive(1'b1, mk_bus(2'd0, 3'd0, 1'b1, 1'b1, 5'd3, 32'h1111, 32'h1000), 1'b1, 32'h0);
      cycle("ldw.acc");
      drive(1'b0, '0, 1'b1, 32'h8899AABB);
      settle("ldw.out");
      check("ldw.result", 70'(ms_to_ws_bus[63:32]), 70'(32'h8899AABB));
      check("ldw.v1", 70'(ms_to_ws_valid), 70'(1'b1));
      tick();
      cycle("ldw.gone");

      // Byte/half extraction, back to back
      ld_bus[0] = mk_bus(2'd2, 3'd1, 1'b1, 1'b1, 5'd4, 32'h0, 32'h2000);
      ld_bus[1] = mk_bus(2'd3, 3'd3, 1'b1, 1'b1, 5'd5, 32'h0, 32'h2004);
      ld_bus[2] = mk_bus(2'd2, 3'd2, 1'b1, 1'b1, 5'd6, 32'h0, 32'h2008);
      ld_bus[3] = mk_bus(2'd0, 3'd4, 1'b1, 1'b1, 5'd7, 32'h0, 32'h200C);
      ld_exp[0] = 32'hFFFFFFFF;
      ld_exp[1] = 32'h00000080;
      ld_exp[2] = 32'hFFFF80FF;
      ld_exp[3] = 32'h00007F01;
      for (int i = 0; i <= 4; i++) begin
         drive(i < 4, (i < 4) ? ld_bus[i] : 79'h0, 1'b1, 32'h80FF7F01);
         settle("ext");
         if (i > 0) check($sformatf("ext.%0d", i - 1), 70'(mem_wdata), 70'(ld_exp[i - 1]));
         tick();
      end

      // Load stalled by writeback while SRAM data moves on
      drive(1'b1, mk_bus(2'd0, 3'd0, 1'b1, 1'b1, 5'd9, 32'h0, 32'h3000), 1'b1, 32'h0);
      cycle("stall.acc");
      drive(1'b0, '0, 1'b0, 32'h12345678);
      cycle("stall.c0");
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, '0, 1'b0, 32'hDEADBEEF);
         settle("stall.c");
         check("stall.hold", 70'(mem_wdata), 70'(32'h12345678));
         tick();
      end
      drive(1'b0, '0, 1'b1, 32'hDEADBEEF);
      settle("stall.go");
      check("stall.handoff", 70'(ms_to_ws_bus[63:32]), 70'(32'h12345678));
      tick();
      drive(1'b1, mk_bus(2'd0, 3'd0, 1'b1, 1'b1, 5'd10, 32'h0, 32'h3004), 1'b1, 32'h0);
      cycle("stall.acc2");
      drive(1'b0, '0, 1'b1, 32'hCAFEF00D);
      settle("stall.after");
      check("stall.holdclr", 70'(mem_wdata), 70'(32'hCAFEF00D));
      tick();

      // Back-to-back ALU ops
      for (int i = 0; i < 7; i++) begin
         drive(i < 6, mk_bus(2'd0, 3'd0, 1'b0, 1'(i % 2 == 0), 5'(i + 11),
                            32'hA000 + 32'(i), 32'h4000 + 32'(4 * i)), 1'b1, $urandom);
         settle("b2b");
         if (i > 0) check($sformatf("b2b.pc%0d", i - 1), 70'(ms_to_ws_bus[31:0]),
                          70'(32'h4000 + 32'(4 * (i - 1))));
         tick();
      end

      // Backpressure with exe still offering
      drive(1'b1, mk_bus(2'd0, 3'd0, 1'b0, 1'b1, 5'd20, 32'hAAAA, 32'h5000), 1'b1, 32'h0);
      cycle("bp.a");
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, mk_bus(2'd0, 3'd0, 1'b0, 1'b1, 5'd21, 32'hBBBB, 32'h5004), 1'b0, 32'h0);
         settle("bp.stall");
         check("bp.allowin0", 70'(ms_allowin), 70'(1'b0));
         check("bp.pcA", 70'(ms_to_ws_bus[31:0]), 70'(32'h5000));
         tick();
      end
      es_to_ms_bus[31:0] = 32'h5004;
      ws_allowin = 1'b1;
      cycle("bp.go");
      drive(1'b0, '0, 1'b1, 32'h0);
      settle("bp.next");
      check("bp.pcB", 70'(ms_to_ws_bus[31:0]), 70'(32'h5004));
      tick();

      // Async reset between edges during a stalled load
      drive(1'b1, mk_bus(2'd0, 3'd0, 1'b1, 1'b1, 5'd22, 32'h0, 32'h6000), 1'b1, 32'h0);
      cycle("rst.acc");
      drive(1'b0, '0, 1'b0, 32'h55AA55AA);
      cycle("rst.stall0");
      drive(1'b0, '0, 1'b0, 32'h0);
      #2;
      resetn = 1'b0;
      #1;
      check_reset_outputs("rst.mid");
      m_valid = 1'b0;
      m_first = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      drive(1'b0, '0, 1'b1, 32'h0);
      cycle("rst.idle");
      drive(1'b1, mk_bus(2'd1, 3'd1, 1'b1, 1'b1, 5'd23, 32'h0, 32'h7000), 1'b1, 32'h0);
      cycle("rst.acc2");
      drive(1'b0, '0, 1'b1, 32'h00008000);
      settle("rst.ld");
      check("rst.ldb", 70'(mem_wdata), 70'(32'hFFFFFF80));
      tick();

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         drive(1'(($urandom % 4) != 0), {15'($urandom), $urandom, $urandom},
               1'(($urandom % 3) != 0), $urandom);
         cycle("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port ws_allowin, input, 1: the writeback stage can accept an instruction.
REQ-004 SHALL have port ms_allowin, output, 1: mem stage can accept from exe.
REQ-005 SHALL have port es_to_ms_valid, input, 1: the exe stage offers an instruction.
REQ-006 SHALL have port es_to_ms_bus, input, 79 bits. Fields from bit 78 down to 0:
- ld_off[1:0], ld_code[2:0], st_code[1:0], mem_we, res_from_mem, gr_we
- dest[4:0], alu_result[31:0], pc[31:0]
REQ-007 SHALL have port ms_to_ws_valid, output, 1: an instruction is offered to writeback.
REQ-008 SHALL have port ms_to_ws_bus, output, 70 bits: {gr_we, dest[4:0], final_result[31:0], pc[31:0]}.
REQ-009 SHALL have port data_sram_rdata, input, 32: synchronous SRAM read data, valid exactly one cycle after the exe-stage request.
REQ-010 SHALL have port mem_waddr, output, 5: destination of the in-flight write for the hazard unit; 0 when no write.
REQ-011 SHALL have port mem_wdata, output, 32: final_result, used for forwarding.
REQ-012 SHALL have port mem_is_load, output, 1: a valid load occupies the stage.

Function
REQ-013 SHALL use ms_ready_go = 1 (no internal stall source).
REQ-014 SHALL set ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
REQ-015 SHALL set ms_to_ws_valid = ms_valid && ms_ready_go.
REQ-016 SHALL update ms_valid <= es_to_ms_valid on every edge where ms_allowin=1; otherwise ms_valid holds.
REQ-017 SHALL capture es_to_ms_bus into the internal bus register only when es_to_ms_valid && ms_allowin; otherwise the register holds.
REQ-018 SHALL set a first-cycle flag when an instruction is accepted and clear it on the next edge.
REQ-019 SHALL capture data_sram_rdata into a hold register, and set hold_valid, when all of the following are true:
- ms_valid, first-cycle flag=1, res_from_mem=1, ws_allowin=0.
REQ-020 SHALL clear hold_valid on any edge where ms_allowin=1.
REQ-021 SHALL use raw = hold_valid ? hold register : data_sram_rdata.
REQ-022 SHALL select the load byte raw[8*ld_off +: 8] and halfword raw[16*ld_off[1] +: 16].
REQ-023 SHALL apply ld_code: 000 ld.w = raw.
REQ-024 SHALL apply ld_code 001 ld.b = sign-extended byte, 011 ld.bu = zero-extended byte.
REQ-025 SHALL apply ld_code 010 ld.h = sign-extended half, 100 ld.hu = zero-extended half.
REQ-026 SHALL apply ld_code 101..111 as ld.w.
REQ-027 SHALL ignore ld_off[0] for halfword loads (no misalignment trap in this stage).
REQ-028 SHALL set final_result = res_from_mem ? load result : alu_result.
REQ-029 SHALL NOT use st_code and mem_we; they are carried in the bus only.
REQ-030 SHALL set mem_waddr = dest & {5{gr_we && ms_valid}}.
REQ-031 SHALL set mem_is_load = ms_valid && res_from_mem.
REQ-032 SHALL, on simultaneous accept from exe and hand-off to writeback, have the new instruction replace the old one with no bubble.
REQ-033 SHALL ensure that a stalled non-load instruction never writes the hold register.

Reset
REQ-034 SHALL, while resetn=0 (asynchronously), clear to 0: ms_valid, first-cycle flag, hold_valid, hold register, bus register.
REQ-035 SHALL, during reset, drive ms_allowin=1, ms_to_ws_valid=0, mem_waddr=0, mem_is_load=0, mem_wdata=0.
REQ-036 SHALL, on reset asserted mid-stall, discard the held instruction and hold data; first accept after release behaves as from power-up.

Verification
REQ-037 SHALL cover ld.w: ld.w, ld_off=0, rdata=0x8899AABB next cycle, ws_allowin=1 -> final_result=0x8899AABB, ms_to_ws_valid 1 for one cycle.
REQ-038 SHALL cover byte/half extension with rdata=0x80FF7F01:
- ld.b ld_off=2 -> 0xFFFFFFFF; ld.bu ld_off=3 -> 0x00000080.
- ld.h ld_off=2 -> 0xFFFF80FF; ld.hu ld_off=0 -> 0x00007F01.
REQ-039 SHALL cover load stall: ld.w accepted with rdata=0x12345678; ws_allowin=0 for 3 cycles while rdata changes to 0xDEADBEEF -> final_result stays 0x12345678 until hand-off; hold_valid clears after.
REQ-040 SHALL cover back-to-back: ALU ops every cycle with ws_allowin=1 -> one output per cycle, pc order preserved, mem_waddr tracks each dest (0 when gr_we=0).
REQ-041 SHALL cover backpressure: ms_valid=1, ws_allowin=0, es_to_ms_valid=1 -> ms_allowin=0, bus register unchanged; ws_allowin=1 -> next instruction accepted same edge.
REQ-042 SHALL cover async reset mid-stall: resetn=0 between clock edges during a stalled load -> ms_to_ws_valid=0 and mem_is_load=0 immediately, ms_allowin=1.
